// File: rtl/sar_if.sv
// SAR controller bus: comparator strobe/decision, DAC trial code and readout.
// master = controller side, slave = analog front end / readout side.
interface sar_if #(
  parameter int NBITS = 8
);
  logic             start;
  logic             dout_p;
  logic             dout_n;
  logic             comp_clk;
  logic [NBITS-1:0] dac_code;
  logic [NBITS-1:0] result;
  logic             valid;
  logic             busy;
  logic             err;

  modport master (
    input  start, dout_p, dout_n,
    output comp_clk, dac_code, result,
    output valid, busy, err
  );

  modport slave (
    output start, dout_p, dout_n,
    input  comp_clk, dac_code, result,
    input  valid, busy, err
  );
endinterface

// File: rtl/sar_logic.sv
// Digital SAR controller: strobes the comparator, resolves one bit per
// trial MSB-first and hands the finished code to the readout.
module sar_logic #(
  parameter int NBITS      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT    = 15
) (
  input logic   clk,
  input logic   rst,
  sar_if.master bus
);
  localparam int CMAX = (TIMEOUT > SETTLE_CYC) ? TIMEOUT : SETTLE_CYC;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int IW   = $clog2(NBITS);

  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EVAL,
    S_RESET
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [NBITS-1:0] dac, dac_nxt;
  logic [NBITS-1:0] res, res_nxt;
  logic             vld, vld_nxt;
  logic             bsy, bsy_nxt;
  logic             er, er_nxt;
  logic             cclk, cclk_nxt;
  logic             dp_m, dp_s;
  logic             dn_m, dn_s;
  logic             decided;
  logic             quiet;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= IDX_TOP;
      dac   <= '0;
      res   <= '0;
      vld   <= 1'b0;
      bsy   <= 1'b0;
      er    <= 1'b0;
      cclk  <= 1'b0;
      dp_m  <= 1'b0;
      dp_s  <= 1'b0;
      dn_m  <= 1'b0;
      dn_s  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      dac   <= dac_nxt;
      res   <= res_nxt;
      vld   <= vld_nxt;
      bsy   <= bsy_nxt;
      er    <= er_nxt;
      cclk  <= cclk_nxt;
      dp_m  <= bus.dout_p;
      dp_s  <= dp_m;
      dn_m  <= bus.dout_n;
      dn_s  <= dn_m;
    end
  end

  // both-high is a metastable/illegal comparator state: not a decision
  assign decided = dp_s ^ dn_s;
  assign quiet   = !dp_s && !dn_s;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    dac_nxt   = dac;
    res_nxt   = res;
    vld_nxt   = 1'b0;
    bsy_nxt   = bsy;
    er_nxt    = er;
    cclk_nxt  = cclk;
    unique case (state)
      S_IDLE: begin
        if (bus.start && !vld) begin
          dac_nxt          = '0;
          dac_nxt[IDX_TOP] = 1'b1;
          idx_nxt          = IDX_TOP;
          er_nxt           = 1'b0;
          bsy_nxt          = 1'b1;
          cnt_nxt          = '0;
          state_nxt        = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == SET_LAST) begin
          cclk_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_EVAL;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_EVAL: begin
        cnt_nxt = cnt + CW'(1);
        if (decided) begin
          dac_nxt[idx] = dp_s;
          cclk_nxt     = 1'b0;
          cnt_nxt      = '0;
          state_nxt    = S_RESET;
        end else if (cnt == TO_LAST) begin
          dac_nxt[idx] = 1'b0;
          er_nxt       = 1'b1;
          cclk_nxt     = 1'b0;
          cnt_nxt      = '0;
          state_nxt    = S_RESET;
        end
      end
      S_RESET: begin
        cnt_nxt = cnt + CW'(1);
        if (quiet || cnt == TO_LAST) begin
          if (!quiet) er_nxt = 1'b1;
          cnt_nxt = '0;
          if (idx == '0) begin
            res_nxt   = dac;
            vld_nxt   = 1'b1;
            bsy_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            idx_nxt          = idx - IW'(1);
            dac_nxt[idx_nxt] = 1'b1;
            state_nxt        = S_SETTLE;
          end
        end
      end
    endcase
  end

  assign bus.comp_clk = cclk;
  assign bus.dac_code = dac;
  assign bus.result   = res;
  assign bus.valid    = vld;
  assign bus.busy     = bsy;
  assign bus.err      = er;
endmodule

// File: tb/tb_sar_logic.sv
// Bench for sar_logic: comparator model, conversion vector table,
// scoreboard of expected words checked on each valid pulse.
module tb_sar_logic;
  logic clk = 1'b0;
  logic rst = 1'b1;

  sar_if #(.NBITS(8)) bus();

  sar_logic #(
    .NBITS(8),
    .SETTLE_CYC(2),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vin;
    logic [1:0] mode;
    logic [7:0] res;
    logic       err;
    int         lat;
    bit         chk_tr;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       err;
    int         lat;
    int         t0;
  } exp_t;

  // mode: 0 normal, 1 stuck low, 2 stuck high, 3 decision delayed 5 clk
  logic [7:0] vin  = '0;
  logic [1:0] mode = '0;
  int         hi_cnt = 0;
  int         cyc = 0;
  int         nchk = 0;
  int         nerr = 0;
  int         vcnt = 0;
  int         pcnt = 0;
  logic       prev_cc = 1'b0;
  logic [7:0] trial [8];
  exp_t       q [$];
  logic       gt;
  logic       en;

  // vin sits mid-bin, so a trial equal to vin resolves as "keep"
  assign gt = ({vin, 1'b1} > {bus.dac_code, 1'b0});
  assign en = bus.comp_clk && (mode != 2'd3 || hi_cnt >= 5);
  assign bus.dout_p = (mode == 2'd2) ? 1'b1 :
                      (mode == 2'd1) ? 1'b0 : (gt & en);
  assign bus.dout_n = (mode == 2'd2) ? 1'b1 :
                      (mode == 2'd1) ? 1'b0 : (~gt & en);

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    hi_cnt <= bus.comp_clk ? hi_cnt + 1 : 0;
  end

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.comp_clk && !prev_cc) begin
      if (pcnt < 8) trial[pcnt] = bus.dac_code;
      pcnt++;
    end
    prev_cc = bus.comp_clk;
    if (bus.valid) begin
      vcnt++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("result", int'(bus.result), int'(e.res));
        chk("err", int'(bus.err), int'(e.err));
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic kick(vec_t v);
    pcnt = 0;
    vin  = v.vin;
    mode = v.mode;
    @(negedge clk);
    bus.start = 1'b1;
    q.push_back('{v.res, v.err, v.lat, cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(string nm);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  vec_t vt [9];
  logic [7:0] exp_tr [8];

  initial begin
    int v0;
    int n;
    vt[0] = '{8'hA5, 2'd0, 8'hA5, 1'b0, 64, 1'b1};
    vt[1] = '{8'h00, 2'd0, 8'h00, 1'b0, 64, 1'b0};
    vt[2] = '{8'hFF, 2'd0, 8'hFF, 1'b0, 64, 1'b0};
    vt[3] = '{8'h3C, 2'd0, 8'h3C, 1'b0, 64, 1'b0};
    vt[4] = '{8'h77, 2'd1, 8'h00, 1'b1, 144, 1'b0};
    vt[5] = '{8'h77, 2'd2, 8'h00, 1'b1, 256, 1'b0};
    vt[6] = '{8'hA5, 2'd3, 8'hA5, 1'b0, 104, 1'b0};
    vt[7] = '{8'h01, 2'd3, 8'h01, 1'b0, 104, 1'b0};
    vt[8] = '{8'h5A, 2'd0, 8'h5A, 1'b0, 64, 1'b0};
    exp_tr[0] = 8'h80; exp_tr[1] = 8'hC0;
    exp_tr[2] = 8'hA0; exp_tr[3] = 8'hB0;
    exp_tr[4] = 8'hA8; exp_tr[5] = 8'hA4;
    exp_tr[6] = 8'hA6; exp_tr[7] = 8'hA5;

    bus.start = 1'b0;
    #12;
    chk("rst_comp_clk", int'(bus.comp_clk), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_dac", int'(bus.dac_code), 0);
    chk("rst_result", int'(bus.result), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      v0 = vcnt;
      kick(vt[i]);
      wait_drain("timeout_vec");
      chk("valid_count", vcnt - v0, 1);
      chk("pulse_count", pcnt, 8);
      if (vt[i].chk_tr)
        for (int j = 0; j < 8; j++)
          chk("trial", int'(trial[j]), int'(exp_tr[j]));
    end

    // asynchronous reset while the comparator is strobed
    kick(vt[3]);
    n = 0;
    while (!bus.comp_clk && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_comp_clk", int'(bus.comp_clk), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_comp_clk", int'(bus.comp_clk), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_valid", int'(bus.valid), 0);
    chk("arst_err", int'(bus.err), 0);
    chk("arst_dac", int'(bus.dac_code), 0);
    chk("arst_result", int'(bus.result), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    kick(vt[0]);
    wait_drain("timeout_post_rst");

    // start re-pulsed mid-conversion
    v0 = vcnt;
    kick(vt[3]);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("timeout_repulse");
    chk("repulse_valids", vcnt - v0, 1);

    // start held across the valid cycle of an errored conversion
    kick(vt[4]);
    n = 0;
    while (!bus.valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", int'(bus.valid), 1);
    vin = 8'h5A;
    mode = 2'd0;
    bus.start = 1'b1;
    @(negedge clk);
    chk("start_in_valid_ignored", int'(bus.busy), 0);
    q.push_back('{8'h5A, 1'b0, 64, cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", int'(bus.busy), 1);
    chk("b2b_err_cleared", int'(bus.err), 0);
    wait_drain("timeout_b2b");

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nerr);
    $finish;
  end
endmodule
